// File: rtl/adci_pkg.sv
// Shared constants, FSM state type and frame builder for the ADC-interface responder.
package adci_pkg;

  localparam int ADCI_FRAME_BITS = 16;
  localparam int ADCI_LEAD_ZEROS = 4;
  localparam int ADCI_DATA_BITS  = 8;
  localparam int ADCI_ADDR_BIT   = 4;
  localparam int ADCI_CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } adci_state_e;

  // Sample framed as 4 leading zeros, 8 data bits MSB-first, 4 trailing zeros.
  function automatic logic [ADCI_FRAME_BITS-1:0] adci_frame(input logic [ADCI_DATA_BITS-1:0] data);
    return {4'b0000, data, 4'b0000};
  endfunction

endpackage

// File: rtl/adci_sync_edge.sv
// N-stage synchronizer for an asynchronous pin with registered rise/fall pulses.
module adci_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic i_din,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;
  logic              r_fall;

  // Synchronizer chain plus one-cycle edge pulses off its last stage.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_din};
      r_prev <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[STAGES-1] & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/adci_responder.sv
// Emulates a 2-channel 8-bit ADC on the serial bus: returns a 16-bit frame per CSN
// and decodes the channel-select bit shifted in by the master.
module adci_responder
  import adci_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      csn,
  input  logic                      sck,
  input  logic                      sdi,
  input  logic [ADCI_DATA_BITS-1:0] ch0_data,
  input  logic [ADCI_DATA_BITS-1:0] ch1_data,
  output logic                      sdo,
  output logic                      sdo_oe,
  output logic                      sel_ch,
  output logic                      frame_done,
  output logic                      frame_err
);

  logic w_csn_rise, w_csn_fall, w_sck_rise, w_sck_fall, w_sdi;
  logic [SYNC_STAGES-1:0] r_sdi_sync;

  adci_state_e r_state, w_state_nxt;
  logic [ADCI_FRAME_BITS-1:0] r_shreg, w_shreg_nxt, w_shifted;
  logic [ADCI_CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic r_next_ch, w_next_ch_nxt, r_sel, w_sel_nxt, r_sdo, w_sdo_nxt, r_oe, w_oe_nxt;
  logic r_done, w_done_nxt, r_err, w_err_nxt, r_sck_low, w_sck_low_nxt;

  // CSN resets low so that, after a reset with CSN held low, a CSN rise must be seen before a new frame.
  adci_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_csn_sync (
    .sys_clk(sys_clk), .rst(rst), .i_din(csn), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
  );

  adci_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sck_sync (
    .sys_clk(sys_clk), .rst(rst), .i_din(sck), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  // Level-only synchronizer for the control bit.
  always_ff @(posedge sys_clk) begin
    if (rst) r_sdi_sync <= '0;
    else     r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
  end
  assign w_sdi = r_sdi_sync[SYNC_STAGES-1];

  // State and datapath registers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_next_ch <= 1'b0;
      r_sel     <= 1'b0;
      r_sdo     <= 1'b0;
      r_oe      <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_sck_low <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_cnt     <= w_cnt_nxt;
      r_next_ch <= w_next_ch_nxt;
      r_sel     <= w_sel_nxt;
      r_sdo     <= w_sdo_nxt;
      r_oe      <= w_oe_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_sck_low <= w_sck_low_nxt;
    end
  end

  // Next-state and next-output logic; CSN edges are tested before SCK edges.
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_cnt_nxt     = r_cnt;
    w_next_ch_nxt = r_next_ch;
    w_sel_nxt     = r_sel;
    w_sdo_nxt     = r_sdo;
    w_oe_nxt      = r_oe;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_sck_low_nxt = r_sck_low;
    w_shifted     = {r_shreg[ADCI_FRAME_BITS-2:0], 1'b0};
    if (!en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_sdo_nxt   = 1'b0;
      w_oe_nxt    = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_sdo_nxt = 1'b0;
          w_oe_nxt  = 1'b0;
          w_cnt_nxt = '0;
          if (w_csn_fall) begin
            w_shreg_nxt   = adci_frame(r_sel ? ch1_data : ch0_data);
            w_sdo_nxt     = w_shreg_nxt[ADCI_FRAME_BITS-1];
            w_oe_nxt      = 1'b1;
            w_sck_low_nxt = 1'b0;
            w_state_nxt   = SHIFT;
          end
        end
        SHIFT: begin
          if (w_csn_rise) begin
            w_err_nxt   = 1'b1;
            w_sdo_nxt   = 1'b0;
            w_oe_nxt    = 1'b0;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            // A rise only counts once SCK has been seen low inside this frame.
            if (w_sck_fall) w_sck_low_nxt = 1'b1;
            if (w_sck_rise && r_sck_low) begin
              w_cnt_nxt   = r_cnt + 5'd1;
              if (r_cnt == ADCI_CNT_W'(ADCI_ADDR_BIT)) w_next_ch_nxt = w_sdi;
              w_shreg_nxt = w_shifted;
              w_sdo_nxt   = w_shifted[ADCI_FRAME_BITS-1];
              if (r_cnt == ADCI_CNT_W'(ADCI_FRAME_BITS-1)) begin
                w_sel_nxt   = r_next_ch;
                w_done_nxt  = 1'b1;
                w_sdo_nxt   = 1'b0;
                w_state_nxt = HOLD;
              end
            end
          end
        end
        HOLD: begin
          w_sdo_nxt = 1'b0;
          w_oe_nxt  = 1'b1;
          if (w_csn_rise) begin
            w_oe_nxt    = 1'b0;
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_sdo_nxt   = 1'b0;
          w_oe_nxt    = 1'b0;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign sdo        = r_sdo;
  assign sdo_oe     = r_oe;
  assign sel_ch     = r_sel;
  assign frame_done = r_done;
  assign frame_err  = r_err;

endmodule
